multicycle_exec_unit: RTL and testbench

Parametrised, sequential successor to the combinational execution unit in the multicycle RISC-V datapath. Keeps the ALU/shift opcode set and the zero/negative flags, generalised to XLEN bits. Adds iterative multiply and divide behind a start/busy/done handshake, which the control FSM uses to stall the EX stage.

---
 rtl/multicycle_exec_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_multicycle_exec_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_exec_unit.sv
// Execution unit: single-cycle ALU/shift ops plus iterative MUL/MULHU/DIVU/REMU.
// Define EXEC_SIGNED_DIV_EN to turn opcodes 14/15 into signed DIV/REM.
module multicycle_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [XLEN-1:0]    operand_A,
  input  logic [XLEN-1:0]    operand_B,
  input  logic [3:0]         opcode,
  input  logic [SHAMT_W-1:0] shift_amount,
  output logic               busy,
  output logic               done,
  output logic [XLEN-1:0]    result,
  output logic               zero_flag,
  output logic               negative_flag
);

  localparam logic [3:0] OpAdd   = 4'd0;
  localparam logic [3:0] OpSub   = 4'd1;
  localparam logic [3:0] OpAnd   = 4'd2;
  localparam logic [3:0] OpOr    = 4'd3;
  localparam logic [3:0] OpXor   = 4'd4;
  localparam logic [3:0] OpSll   = 4'd5;
  localparam logic [3:0] OpSrl   = 4'd6;
  localparam logic [3:0] OpSra   = 4'd7;
  localparam logic [3:0] OpSlt   = 4'd8;
  localparam logic [3:0] OpSltu  = 4'd9;
  localparam logic [3:0] OpMul   = 4'd10;
  localparam logic [3:0] OpMulhu = 4'd11;
  localparam logic [3:0] OpDivu  = 4'd12;
  localparam logic [3:0] OpRemu  = 4'd13;
`ifdef EXEC_SIGNED_DIV_EN
  localparam logic [3:0] OpDiv   = 4'd14;
  localparam logic [3:0] OpRem   = 4'd15;
`endif

  localparam logic [SHAMT_W-1:0] LastStep = SHAMT_W'(XLEN - 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        op_q, op_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  // acc: multiply high half / divide partial remainder
  // lo:  multiplier being consumed / dividend shifting out, quotient shifting in
  logic [XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]   lo_q, lo_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              neg_q, neg_d;
`ifdef EXEC_SIGNED_DIV_EN
  logic              qneg_q, qneg_d;
  logic              rneg_q, rneg_d;
  logic              a_neg, b_neg;
  logic [XLEN-1:0]   a_mag, b_mag;
`endif

  logic [XLEN-1:0]   alu_res;
  logic [XLEN:0]     mul_sum;
  logic [XLEN-1:0]   mul_acc, mul_lo;
  logic [XLEN:0]     div_shift;
  logic              div_ok;
  logic [XLEN-1:0]   div_acc, div_lo;
  logic [XLEN-1:0]   iter_res;
  logic              upd;

  function automatic logic is_iter(input logic [3:0] op);
`ifdef EXEC_SIGNED_DIV_EN
    return op >= OpMul;
`else
    return (op >= OpMul) && (op <= OpRemu);
`endif
  endfunction

  function automatic logic is_mul(input logic [3:0] op);
    return (op == OpMul) || (op == OpMulhu);
  endfunction

  always_comb begin
    alu_res = '0;
    case (opcode)
      OpAdd:   alu_res = operand_A + operand_B;
      OpSub:   alu_res = operand_A - operand_B;
      OpAnd:   alu_res = operand_A & operand_B;
      OpOr:    alu_res = operand_A | operand_B;
      OpXor:   alu_res = operand_A ^ operand_B;
      OpSll:   alu_res = operand_A << shift_amount;
      OpSrl:   alu_res = operand_A >> shift_amount;
      OpSra:   alu_res = XLEN'($signed(operand_A) >>> shift_amount);
      OpSlt:   alu_res = {{(XLEN-1){1'b0}}, $signed(operand_A) < $signed(operand_B)};
      OpSltu:  alu_res = {{(XLEN-1){1'b0}}, operand_A < operand_B};
      default: alu_res = '0;
    endcase
  end

`ifdef EXEC_SIGNED_DIV_EN
  always_comb begin
    a_neg = operand_A[XLEN-1];
    b_neg = operand_B[XLEN-1];
    a_mag = a_neg ? -operand_A : operand_A;
    b_mag = b_neg ? -operand_B : operand_B;
  end
`endif

  // Shift-add multiply step: the product forms in {acc, lo} over XLEN steps.
  always_comb begin
    mul_sum = {1'b0, acc_q} + {1'b0, (lo_q[0] ? opnd_q : '0)};
    mul_acc = mul_sum[XLEN:1];
    mul_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
  end

  // Restoring divide step; a zero divisor always "fits", giving all-ones / dividend.
  always_comb begin
    div_shift = {acc_q, lo_q[XLEN-1]};
    div_ok    = div_shift >= {1'b0, opnd_q};
    div_acc   = div_ok ? (div_shift[XLEN-1:0] - opnd_q) : div_shift[XLEN-1:0];
    div_lo    = {lo_q[XLEN-2:0], div_ok};
  end

  always_comb begin
    iter_res = '0;
    case (op_q)
      OpMul:   iter_res = mul_lo;
      OpMulhu: iter_res = mul_acc;
      OpDivu:  iter_res = div_lo;
      OpRemu:  iter_res = div_acc;
`ifdef EXEC_SIGNED_DIV_EN
      OpDiv:   iter_res = qneg_q ? -div_lo : div_lo;
      OpRem:   iter_res = rneg_q ? -div_acc : div_acc;
`endif
      default: iter_res = '0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    result_d = result_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    upd      = 1'b0;
`ifdef EXEC_SIGNED_DIV_EN
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
`endif
    case (state_q)
      StIdle, StDone: begin
        state_d = StIdle;
        if (start) begin
          if (is_iter(opcode)) begin
            state_d = StCalc;
            op_d    = opcode;
            cnt_d   = '0;
            acc_d   = '0;
            lo_d    = is_mul(opcode) ? operand_B : operand_A;
            opnd_d  = is_mul(opcode) ? operand_A : operand_B;
`ifdef EXEC_SIGNED_DIV_EN
            if (opcode >= 4'd14) begin
              lo_d   = a_mag;
              opnd_d = b_mag;
              qneg_d = (a_neg ^ b_neg) && (operand_B != '0);
              rneg_d = a_neg;
            end
`endif
          end else begin
            state_d  = StDone;
            result_d = alu_res;
            upd      = 1'b1;
          end
        end
      end
      StCalc: begin
        cnt_d = cnt_q + 1'b1;
        if (is_mul(op_q)) begin
          acc_d = mul_acc;
          lo_d  = mul_lo;
        end else begin
          acc_d = div_acc;
          lo_d  = div_lo;
        end
        if (cnt_q == LastStep) begin
          state_d  = StDone;
          result_d = iter_res;
          upd      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
    if (upd) begin
      zero_d = (result_d == '0);
      neg_d  = result_d[XLEN-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      op_q     <= '0;
      cnt_q    <= '0;
      acc_q    <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
`ifdef EXEC_SIGNED_DIV_EN
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
`ifdef EXEC_SIGNED_DIV_EN
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
`endif
    end
  end

  assign busy          = (state_q == StCalc);
  assign done          = (state_q == StDone);
  assign result        = result_q;
  assign zero_flag     = zero_q;
  assign negative_flag = neg_q;

endmodule

// File: tb/tb_multicycle_exec_unit.sv
// Table-driven bench for multicycle_exec_unit with a result scoreboard.
// Signed-divide vectors are included when EXEC_SIGNED_DIV_EN is defined.
module tb_multicycle_exec_unit;

  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] operand_A, operand_B;
  logic [3:0]  opcode;
  logic [4:0]  shift_amount;
  logic        busy, done, zero_flag, negative_flag;
  logic [31:0] result;

  multicycle_exec_unit #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .operand_A     (operand_A),
    .operand_B     (operand_B),
    .opcode        (opcode),
    .shift_amount  (shift_amount),
    .busy          (busy),
    .done          (done),
    .result        (result),
    .zero_flag     (zero_flag),
    .negative_flag (negative_flag)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  sh;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [31:0] res;
    int          lat;
    int          t0;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   cyc = 0;
  int   nchecks = 0;
  int   nfail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic bit iter_op(input logic [3:0] op);
`ifdef EXEC_SIGNED_DIV_EN
    return op >= 4'd10;
`else
    return (op >= 4'd10) && (op <= 4'd13);
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh, input logic [31:0] exp);
    vec_t v;
    v.op = op; v.a = a; v.b = b; v.sh = sh; v.exp = exp;
    vecs.push_back(v);
  endtask

  // Called at a negedge: present a request and record what it must produce.
  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp);
    exp_t e;
    start = 1'b1; opcode = op; operand_A = a; operand_B = b; shift_amount = sh;
    e.res = exp;
    e.lat = iter_op(op) ? XLEN + 1 : 1;
    e.t0  = cyc;
    sb.push_back(e);
  endtask

  // Waits for done (bounded), counting busy cycles; poke fires a start mid-busy.
  task automatic finish_op(input int exp_busy, input bit poke);
    int nb = 0;
    int k = 0;
    @(negedge clk);
    start = 1'b0;
    while (!done && k < 40) begin
      if (busy) nb++;
      if (poke && k == 2) begin
        start = 1'b1; opcode = 4'd0; operand_A = 32'h11; operand_B = 32'h22;
      end else if (poke && k == 3) begin
        start = 1'b0;
        operand_A = 32'hDEAD_BEEF;
      end
      @(negedge clk);
      k++;
    end
    start = 1'b0;
    check("done_within_bound", {31'd0, done}, 32'd1);
    check("busy_cycles", nb, exp_busy);
  endtask

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        nchecks++;
        nfail++;
        $display("FAIL unexpected_done: got done with result %h expected no done", result);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("zero_flag", {31'd0, zero_flag}, {31'd0, e.res == 32'd0});
        check("negative_flag", {31'd0, negative_flag}, {31'd0, e.res[31]});
        check("latency", cyc - e.t0, e.lat);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    rst = 1'b1; start = 1'b0; operand_A = '0; operand_B = '0; opcode = '0; shift_amount = '0;

    add_vec(4'd0,  32'h7FFF_FFFF, 32'h0000_0001, 5'd0,  32'h8000_0000);
    add_vec(4'd1,  32'd5,         32'd5,         5'd0,  32'h0000_0000);
    add_vec(4'd2,  32'hF0F0_1234, 32'h0FF0_FF00, 5'd0,  32'h00F0_1200);
    add_vec(4'd3,  32'hF000_0000, 32'h0000_000F, 5'd0,  32'hF000_000F);
    add_vec(4'd4,  32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0,  32'hF0F0_0F0F);
    add_vec(4'd5,  32'h0000_0001, 32'h0,         5'd31, 32'h8000_0000);
    add_vec(4'd6,  32'h8000_0000, 32'h0,         5'd4,  32'h0800_0000);
    add_vec(4'd7,  32'h8000_0000, 32'h0,         5'd4,  32'hF800_0000);
    add_vec(4'd9,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0001);
    add_vec(4'd8,  32'h0000_0001, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000);
    add_vec(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0000);
    add_vec(4'd11, 32'h0001_0000, 32'h0001_0000, 5'd0,  32'h0000_0001);
    add_vec(4'd10, 32'd7,         32'd6,         5'd0,  32'd42);
    add_vec(4'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0,  32'hFFFF_FFFE);
    add_vec(4'd12, 32'd100,       32'd7,         5'd0,  32'd14);
    add_vec(4'd13, 32'd100,       32'd7,         5'd0,  32'd2);
    add_vec(4'd12, 32'h0000_1234, 32'd0,         5'd0,  32'hFFFF_FFFF);
    add_vec(4'd13, 32'h0000_1234, 32'd0,         5'd0,  32'h0000_1234);
`ifdef EXEC_SIGNED_DIV_EN
    add_vec(4'd14, 32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFD);
    add_vec(4'd15, 32'hFFFF_FFF9, 32'd2,         5'd0,  32'hFFFF_FFFF);
    add_vec(4'd14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h8000_0000);
    add_vec(4'd15, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0,  32'h0000_0000);
    add_vec(4'd14, 32'hFFFF_FFF9, 32'd0,         5'd0,  32'hFFFF_FFFF);
    add_vec(4'd15, 32'hFFFF_FFF9, 32'd0,         5'd0,  32'hFFFF_FFF9);
`else
    add_vec(4'd14, 32'd9,         32'd3,         5'd0,  32'h0000_0000);
    add_vec(4'd15, 32'd9,         32'd3,         5'd0,  32'h0000_0000);
`endif

    repeat (3) @(negedge clk);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_zero_flag", {31'd0, zero_flag}, 32'd0);
    check("reset_negative_flag", {31'd0, negative_flag}, 32'd0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].sh, vecs[i].exp);
      finish_op(iter_op(vecs[i].op) ? XLEN : 0, 1'b0);
    end

    // Start pulses during busy must be ignored; no second done follows.
    @(negedge clk);
    drive(4'd10, 32'h0001_0000, 32'h0001_0000, 5'd0, 32'h0000_0000);
    finish_op(XLEN, 1'b1);
    @(negedge clk);
    check("no_extra_done", {31'd0, done}, 32'd0);

    // Back-to-back: ADD issued in the DONE cycle of a DIVU.
    @(negedge clk);
    drive(4'd12, 32'd100, 32'd7, 5'd0, 32'd14);
    finish_op(XLEN, 1'b0);
    drive(4'd0, 32'd2, 32'd3, 5'd0, 32'd5);
    finish_op(0, 1'b0);

    // Reset mid-CALC aborts the op with no done.
    @(negedge clk);
    drive(4'd10, 32'd3, 32'd5, 5'd0, 32'd15);
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    sb.delete();
    @(negedge clk);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", result, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    rst = 1'b0;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    check("no_done_after_abort", nd, 0);

    check("scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfail);
    $finish;
  end

endmodule
